// File: rtl/key_deb_pkg.sv
// Shared definitions for the key debouncer: FSM state encodings, the default
// key count and a one-hot test helper.
package key_deb_pkg;

    // The downstream 4-to-2 encoder expects exactly four lines.
    localparam int unsigned N_KEYS_DEF = 4;

    // Debouncer FSM state encodings (kept as plain constants for legacy tools).
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] DEBOUNCE = 2'd1;
    localparam logic [1:0] HELD     = 2'd2;
    localparam logic [1:0] RELEASE  = 2'd3;

    // True when exactly one bit of v is set (popcount == 1).
    function automatic logic is_onehot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs, one stage pair per bit.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // First stage may go metastable; second stage gives a clean level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/key_onehot_debounce.sv
// Key front end for the 4-to-2 encoder: synchronizes and debounces raw key
// lines, forwards only single-key presses as a one-hot code with an enable,
// and flags debounced multi-key patterns.
// Optional build macro KEY_REPEAT_EN: while a key stays held, strb re-pulses
// every REPEAT_CYCLES cycles after the initial acceptance pulse.
module key_onehot_debounce
    import key_deb_pkg::*;
#(
    parameter int unsigned N_KEYS        = N_KEYS_DEF,
    parameter int unsigned DEB_CYCLES    = 16,
    parameter int unsigned REPEAT_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key_raw,
    output logic [N_KEYS-1:0] onehot,
    output logic              en,
    output logic              strb,
    output logic              multi_err
);

    localparam int unsigned     CNT_W   = $clog2(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    // Reject illegal configurations at elaboration time.
    if (DEB_CYCLES < 2) begin : g_bad_deb
        $error("DEB_CYCLES must be at least 2");
    end
    if (REPEAT_CYCLES < 2) begin : g_bad_repeat
        $error("REPEAT_CYCLES must be at least 2");
    end

    logic [N_KEYS-1:0] key_s;

    logic [1:0]        state_q, state_d;
    logic [N_KEYS-1:0] cand_q, cand_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_KEYS-1:0] onehot_q, onehot_d;
    logic              en_q, en_d;
    logic              strb_q, strb_d;
    logic              err_q, err_d;
    logic              rpt_fire;

    sync_2ff #(
        .WIDTH (N_KEYS)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (key_raw),
        .q     (key_s)
    );

`ifdef KEY_REPEAT_EN
    localparam int unsigned      RPT_W   = $clog2(REPEAT_CYCLES);
    localparam logic [RPT_W-1:0] RPT_MAX = RPT_W'(REPEAT_CYCLES - 1);

    logic [RPT_W-1:0] rpt_q;

    // Repeat period elapses on the REPEAT_CYCLES-th held cycle after the last pulse.
    always_comb begin
        rpt_fire = (rpt_q == RPT_MAX);
    end

    // Repeat counter runs only while the accepted key is still held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_q <= '0;
        end else if ((state_q == HELD) && (key_s == cand_q)) begin
            rpt_q <= rpt_fire ? '0 : rpt_q + 1'b1;
        end else begin
            rpt_q <= '0;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    // Next-state and registered-output logic of the debounce FSM.
    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        onehot_d = onehot_q;
        en_d     = en_q;
        strb_d   = 1'b0;
        err_d    = err_q;

        unique case (state_q)
            IDLE: begin
                if (key_s != '0) begin
                    cand_d  = key_s;
                    cnt_d   = '0;
                    state_d = DEBOUNCE;
                end
            end

            DEBOUNCE: begin
                if (key_s == '0) begin
                    state_d = IDLE;
                end else if (key_s != cand_q) begin
                    // Pattern still bouncing: restart on the new candidate.
                    cand_d = key_s;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_MAX) begin
                    cnt_d = '0;
                    if (is_onehot(32'(cand_q))) begin
                        onehot_d = cand_q;
                        en_d     = 1'b1;
                        strb_d   = 1'b1;
                        state_d  = HELD;
                    end else begin
                        // Multi-key chord: flag it, never forward it.
                        err_d   = 1'b1;
                        state_d = RELEASE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            HELD: begin
                if (key_s != cand_q) begin
                    // Release or an extra key: withdraw the code on this edge.
                    onehot_d = '0;
                    en_d     = 1'b0;
                    cnt_d    = '0;
                    state_d  = RELEASE;
                end else begin
                    strb_d = rpt_fire;
                end
            end

            RELEASE: begin
                if (key_s != '0) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_MAX) begin
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM and output registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cand_q   <= '0;
            cnt_q    <= '0;
            onehot_q <= '0;
            en_q     <= 1'b0;
            strb_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            onehot_q <= onehot_d;
            en_q     <= en_d;
            strb_q   <= strb_d;
            err_q    <= err_d;
        end
    end

    assign onehot    = onehot_q;
    assign en        = en_q;
    assign strb      = strb_q;
    assign multi_err = err_q;

endmodule

// File: tb/tb_key_onehot_debounce.sv
// Self-checking bench for key_onehot_debounce with DEB_CYCLES=4 and
// REPEAT_CYCLES=8. The reference model works on run lengths of the
// synchronized key pattern rather than on a cycle counter.
module tb_key_onehot_debounce;

    localparam int unsigned NK  = 4;
    localparam int unsigned DEB = 4;
    localparam int unsigned REP = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NK-1:0] key_raw = '0;
    logic [NK-1:0] onehot;
    logic          en;
    logic          strb;
    logic          multi_err;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // Reference model state.
    int            ph;      // 0: waiting for a press, 1: key held, 2: waiting for release
    logic [NK-1:0] s1, ks;  // two-cycle sampling delay of key_raw
    logic [NK-1:0] last;
    int            run, zrun, rpt;
    logic [NK-1:0] m_onehot;
    logic          m_en, m_strb, m_err;

    key_onehot_debounce #(
        .N_KEYS        (NK),
        .DEB_CYCLES    (DEB),
        .REPEAT_CYCLES (REP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_raw   (key_raw),
        .onehot    (onehot),
        .en        (en),
        .strb      (strb),
        .multi_err (multi_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [NK-1:0] got, input logic [NK-1:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        ph = 0; s1 = '0; ks = '0; last = '0;
        run = 0; zrun = 0; rpt = 0;
        m_onehot = '0; m_en = 1'b0; m_strb = 1'b0; m_err = 1'b0;
    endtask

    // Press: accept once DEB+1 consecutive identical nonzero samples are seen.
    // Release: leave once DEB consecutive zero samples follow the drop.
    task automatic model_edge(input logic [NK-1:0] raw);
        m_strb = 1'b0;
        if (ph == 0) begin
            if (ks == '0) begin
                run = 0;
            end else begin
                if (run != 0 && ks == last) run++;
                else run = 1;
                last = ks;
                if (run == DEB + 1) begin
                    run = 0;
                    if ($countones(last) == 1) begin
                        ph = 1; m_onehot = last; m_en = 1'b1; m_strb = 1'b1; rpt = 0;
                    end else begin
                        ph = 2; m_err = 1'b1; zrun = 0;
                    end
                end
            end
        end else if (ph == 1) begin
            if (ks != last) begin
                ph = 2; m_onehot = '0; m_en = 1'b0; zrun = 0;
            end else begin
`ifdef KEY_REPEAT_EN
                rpt++;
                if (rpt == REP) begin
                    m_strb = 1'b1;
                    rpt = 0;
                end
`endif
            end
        end else begin
            if (ks != '0) begin
                zrun = 0;
            end else begin
                zrun++;
                if (zrun == DEB) begin
                    ph = 0; m_err = 1'b0; run = 0;
                end
            end
        end
        ks = s1;
        s1 = raw;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".onehot"}, onehot, m_onehot);
        chk({tag, ".en"}, {3'b000, en}, {3'b000, m_en});
        chk({tag, ".strb"}, {3'b000, strb}, {3'b000, m_strb});
        chk({tag, ".multi_err"}, {3'b000, multi_err}, {3'b000, m_err});
    endtask

    task automatic step(input logic [NK-1:0] v, input string tag);
        key_raw = v;
        @(posedge clk);
        model_edge(v);
        #1;
        check_all(tag);
    endtask

    task automatic hold(input logic [NK-1:0] v, input int n, input string tag);
        for (int i = 0; i < n; i++) step(v, tag);
    endtask

    int strb_seen;

    initial begin
        model_reset();
        #3;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single key: en/onehot/strb after edge 6, strb gone at edge 7.
        for (int i = 0; i < 12; i++) begin
            step(4'b0001, "press1");
            chk("press1_en_edge", {3'b000, en}, (i >= 6) ? 4'd1 : 4'd0);
            chk("press1_strb_edge", {3'b000, strb}, (i == 6) ? 4'd1 : 4'd0);
        end
        hold(4'b0000, 10, "release1");

        // Bounce, then stable: exactly one strb.
        strb_seen = 0;
        hold(4'b0010, 2, "bounce");
        hold(4'b0000, 1, "bounce");
        for (int i = 0; i < 12; i++) begin
            step(4'b0010, "bounce_stable");
            if (strb) strb_seen++;
        end
        chk("bounce_strb_count", 4'(strb_seen), 4'd1);
        hold(4'b0000, 10, "release2");

        // Multi-key chord.
        hold(4'b0101, 10, "multi");
        chk("multi_err_set", {3'b000, multi_err}, 4'd1);
        hold(4'b0000, 10, "multi_release");

        // Re-press during release restarts the zero run.
        hold(4'b1000, 8, "hold8");
        hold(4'b0000, 1, "rel8");
        hold(4'b1000, 3, "repress8");
        hold(4'b0000, 10, "rel8b");
        hold(4'b1000, 8, "hold8b");
        hold(4'b0000, 10, "rel8c");

        // Asynchronous reset while a key is held.
        hold(4'b0010, 8, "pre_reset");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst.onehot", onehot, 4'b0000);
        chk("async_rst.en", {3'b000, en}, 4'd0);
        chk("async_rst.strb", {3'b000, strb}, 4'd0);
        chk("async_rst.multi_err", {3'b000, multi_err}, 4'd0);
        #2;
        rst_n = 1'b1;
        hold(4'b0010, 10, "post_reset");
        hold(4'b0000, 10, "rel_reset");

        // Long hold exercises auto-repeat when enabled.
        hold(4'b0100, 25, "long_hold");
        hold(4'b0000, 10, "rel_long");

        // Randomized segments of zero, single-key and arbitrary patterns.
        for (int s = 0; s < 40; s++) begin
            logic [NK-1:0] v;
            int unsigned   sel;
            sel = $urandom_range(0, 3);
            if (sel == 0) v = '0;
            else if (sel == 3) v = NK'($urandom_range(0, 15));
            else v = NK'(1 << $urandom_range(0, NK - 1));
            hold(v, int'($urandom_range(1, 14)), "random");
        end
        hold(4'b0000, 12, "final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
